// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width and the launch-controller state encoding.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } tx_feed_state_t;

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO: storage, read/write pointers, occupancy count, full/empty flags and a
// one-cycle overflow pulse for rejected pushes. Flush clears the queue at the edge.
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = UART_DATA_W,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              flush,
  output logic [DATA_W-1:0] head_data,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count,
  output logic              overflow
);

  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              overflow_q, overflow_d;
  logic              push_ok_s;
  logic              pop_ok_s;

  // A push may use the slot freed by a same-cycle pop; flush overrides both.
  always_comb begin
    pop_ok_s   = pop & ~empty_q & ~flush;
    push_ok_s  = push & ~flush & (~full_q | pop_ok_s);
    overflow_d = push & full_q & ~pop_ok_s & ~flush;
  end

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok_s) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
    full_d  = (count_d == CNT_MAX);
    empty_d = (count_d == '0);
  end

  // Register FIFO state and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign full      = full_q;
  assign empty     = empty_q;
  assign count     = count_q;
  assign overflow  = overflow_q;

endmodule

// File: rtl/uart_tx_feeder.sv
// Launch controller in front of the UART transmitter: buffers bytes and issues one
// single-cycle start strobe per byte when the transmitter is idle. A byte whose strobe
// is never acknowledged by tx_busy within BUSY_TIMEOUT cycles is abandoned.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int DATA_W       = UART_DATA_W,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     flush,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     tx_busy,
  output logic                     tx_start,
  output logic [DATA_W-1:0]        tx_data
);

  localparam int TW = $clog2(BUSY_TIMEOUT) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);

  tx_feed_state_t    state_q, state_d;
  logic              tx_start_q, tx_start_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              pop_s;
  logic [DATA_W-1:0] head_s;
  logic              fifo_empty_s;

  uart_byte_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (pop_s),
    .flush     (flush),
    .head_data (head_s),
    .full      (full),
    .empty     (fifo_empty_s),
    .count     (count),
    .overflow  (overflow)
  );

  // Launch FSM next-state: pop and strobe from IDLE, then track the busy handshake.
  always_comb begin
    state_d    = state_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    tmo_d      = tmo_q;
    pop_s      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty_s && !tx_busy && !flush) begin
          pop_s      = 1'b1;
          tx_data_d  = head_s;
          tx_start_d = 1'b1;
          tmo_d      = '0;
          state_d    = WAIT_BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          tmo_d   = '0;
          state_d = WAIT_DONE;
        end else if (tmo_q == TMO_LAST) begin
          // Transmitter never took the byte: drop it rather than re-queue.
          tmo_d   = '0;
          state_d = IDLE;
        end else begin
          tmo_d   = tmo_q + TMO_ONE;
          state_d = WAIT_BUSY;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_DONE;
        end
      end
      default: begin
        tmo_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Launch FSM state, timeout counter and registered transmitter outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      tmo_q      <= tmo_d;
    end
  end

  assign empty    = fifo_empty_s;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;

endmodule
